// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the RV32M execute path: operation encodings,
// multiply/divide FSM states and the OP/M-extension instruction constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } muldiv_state_e;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic is_div_op(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic a_is_signed(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_is_signed(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: a shift-add multiply step or a
// restoring divide step over the {hi, lo} accumulator pair.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hi_next = hi;
        lo_next = lo;
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, operand};
        if (is_div) begin
            // A clear borrow means the trial subtraction fits: keep it, quotient bit 1.
            hi_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            {hi_next, lo_next} = {sum, lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: sign-magnitude operands, XLEN-step
// unsigned core, one fix-up cycle, and a fast path for divide special cases.
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            ready_out,
    output logic            valid_out,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN) + 1;

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_in, op_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] hi_q, lo_q, operand_q;
    logic [XLEN-1:0] hi_next, lo_next;
    logic            sign_a_q, sign_b_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_out_q;

    logic            accept, sign_a, sign_b, div_by_zero, overflow, fast;
    logic [XLEN-1:0] mag_a, mag_b, fast_result, fix_result, quo_fix, rem_fix;
    logic [2*XLEN-1:0] prod_fix;

    assign op_in       = muldiv_op_e'(funct3);
    assign accept      = (state_q == IDLE) && valid_in && !kill;
    assign sign_a      = a_is_signed(op_in) && rs1_data[XLEN-1];
    assign sign_b      = b_is_signed(op_in) && rs2_data[XLEN-1];
    assign mag_a       = sign_a ? -rs1_data : rs1_data;
    assign mag_b       = sign_b ? -rs2_data : rs2_data;
    assign div_by_zero = is_div_op(op_in) && (rs2_data == '0);
    assign overflow    = (op_in inside {OP_DIV, OP_REM}) &&
                         (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    assign fast        = div_by_zero || overflow;

    always_comb begin
        fast_result = '0;
        if (div_by_zero)
            fast_result = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : rs1_data;
        else if (op_in == OP_DIV)
            fast_result = rs1_data;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div_op(op_q)),
        .hi      (hi_q),
        .lo      (lo_q),
        .operand (operand_q),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Quotient is negative when signs differ; remainder follows the dividend.
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo_fix  = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    assign rem_fix  = sign_a_q ? -hi_q : hi_q;

    always_comb begin
        fix_result = rem_fix;
        case (op_q)
            OP_MUL:                      fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_result = quo_fix;
            default:                     fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = fast ? DONE : CALC;
            CALC: if (kill) state_d = IDLE;
                  else if (count_q == CW'(XLEN-1)) state_d = FIX;
            FIX:  state_d = kill ? IDLE : DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_MUL;
            rd_q      <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            operand_q <= '0;
            count_q   <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q      <= op_in;
                    rd_q      <= rd_in;
                    sign_a_q  <= sign_a;
                    sign_b_q  <= sign_b;
                    hi_q      <= '0;
                    lo_q      <= is_div_op(op_in) ? mag_a : mag_b;
                    operand_q <= is_div_op(op_in) ? mag_b : mag_a;
                    count_q   <= '0;
                    if (fast) begin
                        result_q <= fast_result;
                        rd_out_q <= rd_in;
                    end
                end
                CALC: begin
                    hi_q    <= hi_next;
                    lo_q    <= lo_next;
                    count_q <= (kill || count_q == CW'(XLEN-1)) ? '0 : count_q + CW'(1);
                end
                FIX: if (!kill) begin
                    result_q <= fix_result;
                    rd_out_q <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign ready_out  = (state_q == IDLE);
    assign valid_out  = (state_q == DONE) && !kill;
    assign result_out = result_q;
    assign rd_out     = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases, kill and
// reset scenarios, and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_in = '0;
    logic        kill = 1'b0;
    logic        ready_out, valid_out;
    logic [31:0] result_out;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .funct3     (funct3),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rd_in      (rd_in),
        .kill       (kill),
        .ready_out  (ready_out),
        .valid_out  (valid_out),
        .result_out (result_out),
        .rd_out     (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics expressed with plain wide arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64, sb64, ub64, sp;
        logic        [63:0] up;
        logic signed [31:0] sa, sb;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ub64 = {32'b0, b};
        sa   = a;
        sb   = b;
        case (f)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin sp = sa64 * sb64; return sp[63:32]; end
            3'd2: begin sp = sa64 * ub64; return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                  else return sa / sb;
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                  else return sa % sb;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f >= 3'd4 && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready_out && n < 100) begin @(posedge clk); #1; n++; end
        check("ready_before_issue", ready_out, 1);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        wait_ready();
        funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // Returns the number of edges from the accept edge to the edge that captures valid_out.
    task automatic wait_valid(output int lat);
        int n = 0;
        while (!valid_out && n < 60) begin @(posedge clk); #1; n++; end
        lat = n + 1;
    endtask

    task automatic count_valid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (valid_out) seen++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        issue(f, a, b, rd);
        wait_valid(lat);
        check({tag, "_latency"}, lat, ref_latency(f, a, b));
        check({tag, "_result"}, result_out, exp);
        check({tag, "_rd"}, rd_out, rd);
        @(posedge clk); #1;
        check({tag, "_pulse"}, valid_out, 0);
        check({tag, "_hold"}, result_out, exp);
    endtask

    initial begin
        int lat, seen;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;

        #12;
        check("reset_ready", ready_out, 1);
        check("reset_valid", valid_out, 0);
        check("reset_result", result_out, 0);
        check("reset_rd", rd_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("mul_7x-3",   3'd0, 32'd7,         32'hFFFF_FFFD, 5'd7,  32'hFFFF_FFEB);
        run_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000);
        run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE);
        run_op("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF);
        run_op("div_-7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD);
        run_op("rem_-7_2",   3'd6, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF);
        run_op("divu_100_7", 3'd5, 32'd100,       32'd7,         5'd6,  32'd14);
        run_op("remu_100_7", 3'd7, 32'd100,       32'd7,         5'd8,  32'd2);
        run_op("div_5_0",    3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF);
        run_op("remu_5_0",   3'd7, 32'd5,         32'd0,         5'd10, 32'd5);
        run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
        run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);
        run_op("mul_zero",   3'd0, 32'd0,         32'd12345,     5'd13, 32'd0);

        // Abort in the middle of the iteration phase.
        issue(3'd0, 32'd1234, 32'd5678, 5'd14);
        repeat (10) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_calc_ready", ready_out, 1);
        count_valid(40, seen);
        check("kill_calc_no_valid", seen, 0);
        run_op("divu_after_kill", 3'd5, 32'd9, 32'd3, 5'd15, 32'd3);

        // Kill landing exactly on the completion cycle.
        issue(3'd5, 32'd50, 32'd5, 5'd16);
        repeat (33) begin @(posedge clk); #1; end
        check("done_reached", ready_out, 0);
        kill = 1'b1;
        #1;
        check("kill_done_valid", valid_out, 0);
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_done_ready", ready_out, 1);
        count_valid(5, seen);
        check("kill_done_no_valid", seen, 0);

        // Kill beats a simultaneous request in IDLE.
        funct3 = 3'd5; rs1_data = 32'd8; rs2_data = 32'd2; rd_in = 5'd17;
        valid_in = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; kill = 1'b0;
        check("kill_idle_ready", ready_out, 1);
        count_valid(40, seen);
        check("kill_idle_no_valid", seen, 0);

        // Requests held while busy must not disturb the op in flight.
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd18);
        funct3 = 3'd4; rs1_data = 32'd99; rs2_data = 32'd3; rd_in = 5'd19; valid_in = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        valid_in = 1'b0;
        check("busy_ready", ready_out, 0);
        lat = 0;
        while (!valid_out && lat < 60) begin @(posedge clk); #1; lat++; end
        check("busy_latency", lat + 21, 34);
        check("busy_result", result_out, ref_result(3'd3, 32'hDEAD_BEEF, 32'h1234_5678));
        check("busy_rd", rd_out, 18);
        @(posedge clk); #1;

        // Asynchronous reset mid-iteration, applied away from the clock edge.
        issue(3'd1, 32'h7654_3210, 32'h0FED_CBA9, 5'd20);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_ready", ready_out, 1);
        check("rst_valid", valid_out, 0);
        check("rst_result", result_out, 0);
        check("rst_rd", rd_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        count_valid(40, seen);
        check("rst_no_valid", seen, 0);

        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom);
            run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, rd, ref_result(f, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
